// File: rtl/mem_lat_pkg.sv
// ---------------------------------------------------------------------------
// mem_lat_pkg
// Shared defaults and sizing helpers for the memory-latency bridge.
//   DEF_*      : default parameter values used by mem_lat_bridge / mem_lat_fifo
//   credit_w() : width of a counter that must hold 0..n inclusive
//   ptr_w()    : width of an index into an n-entry buffer (at least 1 bit)
// ---------------------------------------------------------------------------
package mem_lat_pkg;

    localparam int DEF_DATA_W      = 64;
    localparam int DEF_IN_DEPTH    = 4;
    localparam int DEF_OUT_DEPTH   = 8;
    localparam int DEF_OUT_CREDITS = 4;
    localparam int DEF_LAT_W       = 16;
    localparam int DEF_CNT_W       = 32;

    // ceil(log2(n+1)): enough bits to represent the value n itself.
    function automatic int credit_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_lat_fifo.sv
// ---------------------------------------------------------------------------
// mem_lat_fifo
// First-word fall-through FIFO used as the NoC2 ingress buffer.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write strobe and data; ignored while full
//   pop        : read strobe; ignored while empty
//   dout       : current head entry (valid whenever empty=0)
//   full/empty : occupancy flags
// A push and pop in the same cycle on a full FIFO drops the push, because
// full is decided from the registered occupancy only.
// ---------------------------------------------------------------------------
module mem_lat_fifo
    import mem_lat_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_IN_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = credit_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push_ok;
    logic              pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_lat_bridge.sv
// ---------------------------------------------------------------------------
// mem_lat_bridge
// Bridges a NoC2/NoC3 credit-based channel pair to a val/rdy memory
// controller and adds a programmable response latency.
//   core_ref_clk, sys_rst_n      : clock, asynchronous active-low reset
//   noc2_data/valid, noc2_yummy  : ingress flits, credit returned per pop
//   mc_req_data/val/rdy          : request path (ingress FIFO head, FWFT)
//   mc_rsp_data/val/rdy          : response path into the delay buffer
//   noc3_data/valid, noc3_yummy  : egress flits, downstream credit return
//   lat_cfg                      : extra latency applied to new responses
//   flit_i_cnt, flit_o_cnt       : saturating flit counters
//   mem_valid_in, mem_valid_out  : request / response handshake pulses
//   ovf_err                      : sticky ingress overflow
// ---------------------------------------------------------------------------
module mem_lat_bridge
    import mem_lat_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IN_DEPTH    = DEF_IN_DEPTH,
    parameter int OUT_DEPTH   = DEF_OUT_DEPTH,
    parameter int OUT_CREDITS = DEF_OUT_CREDITS,
    parameter int LAT_W       = DEF_LAT_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              core_ref_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] noc2_data,
    input  logic              noc2_valid,
    output logic              noc2_yummy,
    output logic [DATA_W-1:0] mc_req_data,
    output logic              mc_req_val,
    input  logic              mc_req_rdy,
    input  logic [DATA_W-1:0] mc_rsp_data,
    input  logic              mc_rsp_val,
    output logic              mc_rsp_rdy,
    output logic [DATA_W-1:0] noc3_data,
    output logic              noc3_valid,
    input  logic              noc3_yummy,
    input  logic [LAT_W-1:0]  lat_cfg,
    output logic [CNT_W-1:0]  flit_i_cnt,
    output logic [CNT_W-1:0]  flit_o_cnt,
    output logic              mem_valid_in,
    output logic              mem_valid_out,
    output logic              ovf_err
);

    localparam int CRED_W = credit_w(OUT_CREDITS);
    localparam int OPW    = ptr_w(OUT_DEPTH);
    localparam int OCW    = credit_w(OUT_DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
        return (v == '0) ? v : v - LAT_W'(1);
    endfunction

    function automatic logic [OPW-1:0] optr_inc(input logic [OPW-1:0] p);
        return (p == OPW'(OUT_DEPTH - 1)) ? '0 : p + OPW'(1);
    endfunction

    // ---- stage p0: ingress FIFO and request handshake ----
    logic in_push;
    logic in_pop;
    logic in_full;
    logic in_empty;

    assign in_push      = noc2_valid && !in_full;
    assign mc_req_val   = !in_empty;
    assign in_pop       = mc_req_val && mc_req_rdy;
    assign mem_valid_in = in_pop;

    mem_lat_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH)
    ) u_in_fifo (
        .clk   (core_ref_clk),
        .rst_n (sys_rst_n),
        .push  (in_push),
        .din   (noc2_data),
        .pop   (in_pop),
        .dout  (mc_req_data),
        .full  (in_full),
        .empty (in_empty)
    );

    // ---- stage p1: ingress credit return, overflow, input counter ----
    logic             yummy_p1;
    logic             ovf_p1;
    logic [CNT_W-1:0] flit_i_p1;

    always_ff @(posedge core_ref_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            yummy_p1  <= 1'b0;
            ovf_p1    <= 1'b0;
            flit_i_p1 <= '0;
        end else begin
            yummy_p1 <= in_pop;
            if (noc2_valid && in_full) ovf_p1 <= 1'b1;
            if (in_push) flit_i_p1 <= sat_inc(flit_i_p1);
        end
    end

    assign noc2_yummy = yummy_p1;
    assign ovf_err    = ovf_p1;
    assign flit_i_cnt = flit_i_p1;

    // ---- stage p0: delay buffer, send decision, credit accounting ----
    logic [DATA_W-1:0] dly_data [OUT_DEPTH];
    logic [LAT_W-1:0]  dly_cnt  [OUT_DEPTH];
    logic [OPW-1:0]    head;
    logic [OPW-1:0]    tail;
    logic [OCW-1:0]    dly_count;
    logic [CRED_W-1:0] credits;
    logic              dly_full;
    logic              dly_empty;
    logic              head_rdy;
    logic              send_head;
    logic              rsp_acc;
    logic              bypass;
    logic              send;
    logic              dly_wr;
    logic              yummy_acc;

    assign dly_full  = (dly_count == OCW'(OUT_DEPTH));
    assign dly_empty = (dly_count == '0);
    // noc3_valid is registered, so the head is launched one cycle before its
    // countdown would reach zero; a count of 1 means "leaves on this edge".
    assign head_rdy  = !dly_empty && (dly_cnt[head] <= LAT_W'(1));
    assign send_head = head_rdy && (credits != '0);
    // A full buffer frees its head this cycle, so it can still take a response.
    assign mc_rsp_rdy    = !dly_full || send_head;
    assign rsp_acc       = mc_rsp_val && mc_rsp_rdy;
    assign mem_valid_out = rsp_acc;
    // Zero-latency response into an empty buffer skips storage entirely so it
    // appears on noc3 the very next cycle.
    assign bypass    = rsp_acc && dly_empty && (lat_cfg == '0) && (credits != '0);
    assign send      = send_head || bypass;
    assign dly_wr    = rsp_acc && !bypass;
    assign yummy_acc = noc3_yummy && (credits != CRED_W'(OUT_CREDITS));

    // ---- stage p1: egress register, buffer and credit state ----
    logic              noc3_vld_p1;
    logic [DATA_W-1:0] noc3_data_p1;
    logic [CNT_W-1:0]  flit_o_p1;

    always_ff @(posedge core_ref_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            head         <= '0;
            tail         <= '0;
            dly_count    <= '0;
            credits      <= CRED_W'(OUT_CREDITS);
            noc3_vld_p1  <= 1'b0;
            noc3_data_p1 <= '0;
            flit_o_p1    <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) dly_cnt[i] <= '0;
        end else begin
            noc3_vld_p1 <= send;
            if (send) begin
                noc3_data_p1 <= bypass ? mc_rsp_data : dly_data[head];
                flit_o_p1    <= sat_inc(flit_o_p1);
            end
            if (send_head) head <= optr_inc(head);
            if (dly_wr)    tail <= optr_inc(tail);
            case ({dly_wr, send_head})
                2'b10:   dly_count <= dly_count + OCW'(1);
                2'b01:   dly_count <= dly_count - OCW'(1);
                default: dly_count <= dly_count;
            endcase
            for (int i = 0; i < OUT_DEPTH; i++) begin
                if (dly_wr && (OPW'(i) == tail)) dly_cnt[i] <= lat_cfg;
                else                             dly_cnt[i] <= sat_dec(dly_cnt[i]);
            end
            case ({send, yummy_acc})
                2'b10:   credits <= credits - CRED_W'(1);
                2'b01:   credits <= credits + CRED_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge core_ref_clk) begin
        if (dly_wr) dly_data[tail] <= mc_rsp_data;
    end

    assign noc3_valid = noc3_vld_p1;
    assign noc3_data  = noc3_data_p1;
    assign flit_o_cnt = flit_o_p1;

endmodule

// File: tb/tb_mem_lat_bridge.sv
`timescale 1ns/1ps
module tb_mem_lat_bridge;

    localparam int DATA_W      = 64;
    localparam int IN_DEPTH    = 4;
    localparam int OUT_DEPTH   = 8;
    localparam int OUT_CREDITS = 2;
    localparam int LAT_W       = 16;
    localparam int CNT_W       = 4;

    logic              core_ref_clk = 1'b0;
    logic              sys_rst_n    = 1'b0;
    logic [DATA_W-1:0] noc2_data    = '0;
    logic              noc2_valid   = 1'b0;
    logic              noc2_yummy;
    logic [DATA_W-1:0] mc_req_data;
    logic              mc_req_val;
    logic              mc_req_rdy   = 1'b0;
    logic [DATA_W-1:0] mc_rsp_data  = '0;
    logic              mc_rsp_val   = 1'b0;
    logic              mc_rsp_rdy;
    logic [DATA_W-1:0] noc3_data;
    logic              noc3_valid;
    logic              noc3_yummy;
    logic [LAT_W-1:0]  lat_cfg      = '0;
    logic [CNT_W-1:0]  flit_i_cnt;
    logic [CNT_W-1:0]  flit_o_cnt;
    logic              mem_valid_in;
    logic              mem_valid_out;
    logic              ovf_err;

    logic auto_yummy   = 1'b0;
    logic manual_yummy = 1'b0;
    assign noc3_yummy = (auto_yummy & noc3_valid) | manual_yummy;

    always #5 core_ref_clk = ~core_ref_clk;

    int cyc = 0;
    always @(posedge core_ref_clk) cyc <= cyc + 1;

    mem_lat_bridge #(
        .DATA_W      (DATA_W),
        .IN_DEPTH    (IN_DEPTH),
        .OUT_DEPTH   (OUT_DEPTH),
        .OUT_CREDITS (OUT_CREDITS),
        .LAT_W       (LAT_W),
        .CNT_W       (CNT_W)
    ) dut (
        .core_ref_clk  (core_ref_clk),
        .sys_rst_n     (sys_rst_n),
        .noc2_data     (noc2_data),
        .noc2_valid    (noc2_valid),
        .noc2_yummy    (noc2_yummy),
        .mc_req_data   (mc_req_data),
        .mc_req_val    (mc_req_val),
        .mc_req_rdy    (mc_req_rdy),
        .mc_rsp_data   (mc_rsp_data),
        .mc_rsp_val    (mc_rsp_val),
        .mc_rsp_rdy    (mc_rsp_rdy),
        .noc3_data     (noc3_data),
        .noc3_valid    (noc3_valid),
        .noc3_yummy    (noc3_yummy),
        .lat_cfg       (lat_cfg),
        .flit_i_cnt    (flit_i_cnt),
        .flit_o_cnt    (flit_o_cnt),
        .mem_valid_in  (mem_valid_in),
        .mem_valid_out (mem_valid_out),
        .ovf_err       (ovf_err)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;   // -1: arrival cycle not checked
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] in_q[$];

    int   n_tests      = 0;
    int   n_fail       = 0;
    int   noc3_seen    = 0;
    int   pops_seen    = 0;
    int   yummy_seen   = 0;
    int   last_exp     = 0;
    logic pop_prev     = 1'b0;
    logic timing_known = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t        e;
        logic [63:0] d;
        forever begin
            @(negedge core_ref_clk);
            if (!sys_rst_n) begin
                pop_prev = 1'b0;
            end else begin
                if (pop_prev || noc2_yummy) chk("noc2_yummy", noc2_yummy, pop_prev);
                if (noc2_yummy) yummy_seen++;
                if (mem_valid_in) begin
                    pops_seen++;
                    if (in_q.size() == 0) chk("req_unexpected", mem_valid_in, 0);
                    else begin
                        d = in_q.pop_front();
                        chk("req_data", mc_req_data, d);
                    end
                end
                pop_prev = mem_valid_in;
                if (noc3_valid) begin
                    noc3_seen++;
                    if (sb_q.size() == 0) chk("noc3_unexpected", noc3_valid, 0);
                    else begin
                        e = sb_q.pop_front();
                        chk("noc3_data", noc3_data, e.data);
                        if (e.cyc >= 0) chk("noc3_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge core_ref_clk);
            #1;
        end
    endtask

    task automatic drive_rsp(input logic [63:0] d, output int t_acc);
        int   n = 0;
        int   lo;
        exp_t e;
        mc_rsp_val  = 1'b1;
        mc_rsp_data = d;
        while (!mc_rsp_rdy && n < 200) begin
            step(1);
            n++;
        end
        t_acc = cyc;
        if (!mc_rsp_rdy) chk("rsp_rdy_timeout", mc_rsp_rdy, 1);
        else begin
            e.data = d;
            if (timing_known) begin
                lo    = cyc + 1 + int'(lat_cfg);
                e.cyc = (lo > last_exp) ? lo : last_exp + 1;
                last_exp = e.cyc;
            end else begin
                e.cyc = -1;
            end
            sb_q.push_back(e);
        end
        step(1);
        mc_rsp_val = 1'b0;
    endtask

    task automatic push_flit(input logic [63:0] d, input logic accept);
        noc2_valid = 1'b1;
        noc2_data  = d;
        if (accept) in_q.push_back(d);
        step(1);
        noc2_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((sb_q.size() != 0 || in_q.size() != 0) && n < bound) begin
            step(1);
            n++;
        end
        chk("drain", sb_q.size() + in_q.size(), 0);
        step(2);
    endtask

    initial begin
        int t0;
        int t;
        int base;
        fork
            monitor();
            begin
                #2ms;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        step(3);
        chk("rst_noc2_yummy", noc2_yummy, 0);
        chk("rst_mc_req_val", mc_req_val, 0);
        chk("rst_noc3_valid", noc3_valid, 0);
        chk("rst_ovf_err", ovf_err, 0);
        chk("rst_flit_i", flit_i_cnt, 0);
        chk("rst_flit_o", flit_o_cnt, 0);
        sys_rst_n = 1'b1;
        @(negedge core_ref_clk);
        chk("post_rst_rsp_rdy", mc_rsp_rdy, 1);
        chk("post_rst_noc3_valid", noc3_valid, 0);
        chk("post_rst_req_val", mc_req_val, 0);
        chk("post_rst_ovf", ovf_err, 0);
        step(2);

        // Zero latency, one response
        auto_yummy = 1'b1;
        lat_cfg    = 16'd0;
        drive_rsp(64'h1111_0000_0000_0001, t);
        wait_drain(20);
        chk("lat0_flit_o", flit_o_cnt, 1);

        // Latency 20, three back-to-back responses
        lat_cfg = 16'd20;
        drive_rsp(64'h2222_0000_0000_0001, t0);
        drive_rsp(64'h2222_0000_0000_0002, t);
        drive_rsp(64'h2222_0000_0000_0003, t);
        wait_drain(60);
        chk("lat20_flit_o", flit_o_cnt, 4);

        // Latency change 50 -> 5 while the 50-cycle flit is buffered
        lat_cfg = 16'd50;
        drive_rsp(64'h3333_0000_0000_0050, t);
        lat_cfg = 16'd5;
        drive_rsp(64'h3333_0000_0000_0005, t);
        wait_drain(100);
        chk("latchg_flit_o", flit_o_cnt, 6);

        // Delay buffer full; a new response is taken as the head leaves
        lat_cfg = 16'd30;
        drive_rsp(64'h4444_0000_0000_0000, t0);
        for (int i = 1; i < OUT_DEPTH; i++) drive_rsp(64'h4444_0000_0000_0000 + 64'(i), t);
        chk("full_rsp_rdy", mc_rsp_rdy, 0);
        drive_rsp(64'h4444_0000_0000_00FF, t);
        chk("full_accept_cycle", t, t0 + 30);
        wait_drain(120);
        chk("full_flit_o", flit_o_cnt, 15);

        // Credits: surplus yummies ignored, stall at zero, resume per yummy
        manual_yummy = 1'b1;
        step(2);
        manual_yummy = 1'b0;
        auto_yummy   = 1'b0;
        timing_known = 1'b0;
        lat_cfg      = 16'd0;
        base = noc3_seen;
        for (int i = 0; i < 5; i++) drive_rsp(64'h5555_0000_0000_0000 + 64'(i), t);
        step(10);
        chk("cred_stall_sends", noc3_seen - base, 2);
        chk("cred_stall_pending", sb_q.size(), 3);
        chk("cred_stall_rsp_rdy", mc_rsp_rdy, 1);
        manual_yummy = 1'b1;
        step(1);
        manual_yummy = 1'b0;
        step(5);
        chk("cred_one_yummy", noc3_seen - base, 3);
        manual_yummy = 1'b1;
        step(5);
        manual_yummy = 1'b0;
        wait_drain(20);
        chk("cred_all_sends", noc3_seen - base, 5);
        chk("flit_o_saturated", flit_o_cnt, 15);

        // Ingress overflow and back-pressure
        mc_req_rdy = 1'b0;
        base = pops_seen;
        t    = yummy_seen;
        for (int i = 0; i < 5; i++) begin
            push_flit(64'hA0 + 64'(i), (i < IN_DEPTH));
            if (i == IN_DEPTH - 1) chk("ovf_before_drop", ovf_err, 0);
        end
        chk("ovf_after_drop", ovf_err, 1);
        chk("ing_flit_i", flit_i_cnt, 4);
        chk("ing_req_val", mc_req_val, 1);
        chk("ing_req_head", mc_req_data, 64'hA0);
        // Push and pop together on a full FIFO: push is dropped
        mc_req_rdy = 1'b1;
        push_flit(64'hA5, 1'b0);
        step(6);
        chk("ing_pops", pops_seen - base, 4);
        chk("ing_yummies", yummy_seen - t, 4);
        chk("ing_flit_i_after", flit_i_cnt, 4);
        chk("ing_req_val_empty", mc_req_val, 0);
        for (int i = 0; i < 14; i++) push_flit(64'hB0 + 64'(i), 1'b1);
        wait_drain(20);
        chk("flit_i_saturated", flit_i_cnt, 15);
        chk("ovf_sticky", ovf_err, 1);

        // Mid-stream reset
        lat_cfg = 16'd0;
        drive_rsp(64'h6666_0000_0000_0000, t);
        step(3);
        lat_cfg = 16'd40;
        drive_rsp(64'h6666_0000_0000_0001, t);
        drive_rsp(64'h6666_0000_0000_0002, t);
        mc_req_rdy = 1'b0;
        push_flit(64'hD0, 1'b1);
        push_flit(64'hD1, 1'b1);
        @(negedge core_ref_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        sb_q.delete();
        in_q.delete();
        chk("mid_rst_req_val", mc_req_val, 0);
        chk("mid_rst_noc3_valid", noc3_valid, 0);
        chk("mid_rst_noc3_data", noc3_data, 0);
        chk("mid_rst_ovf", ovf_err, 0);
        chk("mid_rst_flit_i", flit_i_cnt, 0);
        chk("mid_rst_flit_o", flit_o_cnt, 0);
        chk("mid_rst_yummy", noc2_yummy, 0);
        step(2);
        sys_rst_n  = 1'b1;
        mc_req_rdy = 1'b1;
        base = noc3_seen;
        t0   = yummy_seen;
        step(60);
        chk("post_rst_no_noc3", noc3_seen - base, 0);
        chk("post_rst_no_yummy", yummy_seen - t0, 0);
        chk("post_rst_rsp_rdy2", mc_rsp_rdy, 1);
        // Credits are back at OUT_CREDITS: exactly two sends before stalling
        lat_cfg = 16'd0;
        for (int i = 0; i < 3; i++) drive_rsp(64'h7777_0000_0000_0000 + 64'(i), t);
        step(8);
        chk("post_rst_cred_sends", noc3_seen - base, 2);
        chk("post_rst_cred_pending", sb_q.size(), 1);
        manual_yummy = 1'b1;
        step(1);
        manual_yummy = 1'b0;
        wait_drain(20);
        chk("post_rst_flit_o", flit_o_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lat_bridge.md
MEM_LAT_BRIDGE -- requirements
Module: mem_lat_bridge

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 64, NoC flit width.
- IN_DEPTH, 4, ingress FIFO entries; also the credits the upstream NoC2 sender holds.
- OUT_DEPTH, 8, egress delay-buffer entries.
- OUT_CREDITS, 4, initial NoC3 downstream credits.
- LAT_W, 16, latency-config width.
- CNT_W, 32, flit-counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- core_ref_clk, in, 1, sole clock.
- sys_rst_n, in, 1, asynchronous active-low reset.
- noc2_data, in, DATA_W, NoC2 credit-channel flit.
- noc2_valid, in, 1, flit strobe.
- noc2_yummy, out, 1, credit return.
- mc_req_data, out, DATA_W, val/rdy request to the memory controller.
- mc_req_val, out, 1, request valid.
- mc_req_rdy, in, 1, request ready.
- mc_rsp_data, in, DATA_W, val/rdy response from the memory controller.
- mc_rsp_val, in, 1, response valid.
- mc_rsp_rdy, out, 1, response ready.
- noc3_data, out, DATA_W, NoC3 credit-channel flit.
- noc3_valid, out, 1, flit strobe.
- noc3_yummy, in, 1, downstream credit return.
- lat_cfg, in, LAT_W, extra response latency in cycles.
- flit_i_cnt, out, CNT_W, NoC2 flits accepted.
- flit_o_cnt, out, CNT_W, NoC3 flits sent.
- mem_valid_in, out, 1, request handshake pulse.
- mem_valid_out, out, 1, response handshake pulse.
- ovf_err, out, 1, sticky ingress overflow flag.

REQ-003 Clocking and reset SHALL be fixed: one clock, core_ref_clk; reset sys_rst_n is asynchronous and active-low.

Function
REQ-004 Every cycle with noc2_valid=1 SHALL push noc2_data into the ingress FIFO when it is not full.
REQ-005 When noc2_valid=1 and the ingress FIFO is full, the flit SHALL be dropped and ovf_err SHALL be set until reset.
REQ-006 mc_req_val SHALL equal ingress-not-empty, and mc_req_data SHALL be the FIFO head (first-word fall-through).
REQ-007 A pop SHALL occur on mc_req_val&mc_req_rdy; noc2_yummy SHALL pulse exactly once, in the cycle after each pop.
REQ-008 A simultaneous push and pop on a full ingress FIFO SHALL be treated as full, so the push is dropped.
REQ-009 mc_rsp_rdy SHALL equal delay-buffer-not-full; each mc_rsp_val&mc_rsp_rdy SHALL write the data and a countdown loaded with the current lat_cfg into the tail entry.
REQ-010 Each valid delay-buffer entry countdown SHALL decrement by 1 per cycle, saturating at 0.
REQ-011 A lat_cfg change SHALL affect only responses accepted after the change.
REQ-012 The head entry SHALL be sent when its countdown=0 and the credit count is >0, in order: noc3_valid is a registered one-cycle pulse with noc3_data, and the entry is freed.
REQ-013 Latency: a response accepted in cycle t SHALL appear on noc3_valid no earlier than t+1+lat_cfg, and exactly then when credits are available and no older flit is pending.
REQ-014 The credit counter SHALL be ceil(log2(OUT_CREDITS+1)) bits wide and reset to OUT_CREDITS.
REQ-015 The credit counter SHALL change by -1 per send and +1 per noc3_yummy; a send and a yummy in the same cycle SHALL leave it unchanged.
REQ-016 A yummy arriving with the counter at OUT_CREDITS SHALL be ignored.
REQ-017 A delay buffer that is full while the head is sent SHALL accept a new response in the same cycle.
REQ-018 mem_valid_in SHALL equal mc_req_val&mc_req_rdy and mem_valid_out SHALL equal mc_rsp_val&mc_rsp_rdy, both combinational.
REQ-019 flit_i_cnt SHALL increment per accepted NoC2 flit, excluding drops; flit_o_cnt SHALL increment per noc3_valid pulse.
REQ-020 Both counters SHALL saturate at all-ones.

Reset
REQ-021 Asserting sys_rst_n low SHALL, at any time, asynchronously empty both buffers, zero all countdowns and counters, and set the credit count to OUT_CREDITS.
REQ-022 During and on exit from reset, noc2_yummy, mc_req_val, noc3_valid and ovf_err SHALL be 0; mc_rsp_rdy SHALL be 1 after reset deassertion.
REQ-023 In-flight flits at reset SHALL be discarded, with no yummy issued for them.

Structure
REQ-024 Parameter defaults and the credit-width function SHALL reside in shared package mem_lat_pkg.
REQ-025 The ingress FIFO SHALL be a separate sub-module mem_lat_fifo (parametrised width/depth, FWFT, full/empty flags); the delay buffer and credit logic SHALL be inline.

Verification
REQ-026 lat_cfg=0, one response in cycle 10 with ample credits -> noc3_valid in cycle 11, flit_o_cnt=1.
REQ-027 lat_cfg=20, three back-to-back responses in cycles 10-12 -> noc3_valid in cycles 31, 32 and 33, in order.
REQ-028 OUT_CREDITS=2, five responses with lat_cfg=0 and no yummy -> two sends, then stall; one yummy -> one more send.
REQ-029 IN_DEPTH=4, mc_req_rdy=0, five NoC2 flits -> four held, ovf_err=1, flit_i_cnt=4; mc_req_rdy=1 -> four pops, four noc2_yummy pulses.
REQ-030 lat_cfg changes 50->5 while a 50-cycle flit is buffered -> the later flit waits behind the head, and order is preserved.
REQ-031 sys_rst_n low mid-stream -> outputs zero immediately, the credit count returns to OUT_CREDITS, and there are no spurious pulses after release.
